// File: rtl/rv32_pkg.sv
// Shared rv32i_seg pipeline types and constants.
// Imported by the fetch stage and the generic pipeline register.
package rv32_pkg;

   localparam int          XLEN_W           = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // ADDI x0,x0,0
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } ifid_t;

   // Value held by an empty IF/ID slot, both after reset and after a flush.
   localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};

endpackage

// File: rtl/if_stage_ifid_reg.sv
// Generic pipeline register with hold and flush; priority is flush > hold > load.
// Reused for ID/EX, EX/MEM and MEM/WB by overriding the payload type and bubble value.
module ifid_reg
   import rv32_pkg::*;
#(
   parameter type T      = ifid_t,
   parameter T    BUBBLE = IFID_BUBBLE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hold_i,
   input  logic flush_i,
   input  T     d_i,
   output T     q_o
);

   T data_q;
   T data_d;

   always_comb begin
      data_d = data_q;
      if (flush_i) begin
         data_d = BUBBLE;
      end else if (!hold_i) begin
         data_d = d_i;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= BUBBLE;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem address and IF/ID register.
// Define IF_STAGE_PERF_EN to add saturating perf_fetched / perf_bubbles counters.
module if_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          XLEN     = XLEN_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            ifid_valid,
   output logic [31:0]     ifid_instr,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_pc4,
   output logic            misalign_err
`ifdef IF_STAGE_PERF_EN
  ,output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_bubbles
`endif
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic            misalign_q, misalign_d;
   logic            advance;
   ifid_t           ifid_d, ifid_q;

   assign pc_plus4 = pc_q + 32'd4;
   assign advance  = !redirect && !stall;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
      if (redirect) begin
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end
      end else if (!stall) begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign ifid_d = '{valid: 1'b1, instr: imem_rdata, pc: pc_q, pc4: pc_plus4};

   ifid_reg #(
      .T      (ifid_t),
      .BUBBLE (IFID_BUBBLE)
   ) u_ifid_reg (
      .clk     (clk),
      .rst_n   (reset),
      .hold_i  (stall),
      .flush_i (redirect),
      .d_i     (ifid_d),
      .q_o     (ifid_q)
   );

   assign imem_addr    = pc_q;
   assign ifid_valid   = ifid_q.valid;
   assign ifid_instr   = ifid_q.instr;
   assign ifid_pc      = ifid_q.pc;
   assign ifid_pc4     = ifid_q.pc4;
   assign misalign_err = misalign_q;

`ifdef IF_STAGE_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] bubbles_q, bubbles_d;

   // Counters saturate at all-ones rather than wrapping.
   always_comb begin
      fetched_d = fetched_q;
      bubbles_d = bubbles_q;
      if (advance) begin
         if (fetched_q != 32'hFFFF_FFFF) fetched_d = fetched_q + 32'd1;
      end else begin
         if (bubbles_q != 32'hFFFF_FFFF) bubbles_d = bubbles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetched_q <= 32'h0;
         bubbles_q <= 32'h0;
      end else begin
         fetched_q <= fetched_d;
         bubbles_q <= bubbles_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_bubbles = bubbles_q;
`else
   logic unused_advance;
   assign unused_advance = advance;
`endif

endmodule
